// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: a single-outstanding-request fetch FSM that feeds
// the IF/ID register. It handles redirects (branch over jump) at any point
// and silently drops data returned for a stale address.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] rd_out,
   output logic [31:0] newPC_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_DISCARD = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] rd_q, rd_d;
   logic [31:0] npc_q, npc_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;

   logic        redirect;
   logic [31:0] target;
   logic        slot_free;

   // Redirect decode: branch wins over jump, targets are word aligned.
   always_comb begin
      redirect  = branch_taken | jump;
      target    = (branch_taken ? branch_target : jump_target) & ~32'h3;
      slot_free = ~valid_q | ~stall_in;
   end

   // State and datapath registers; reset dominates everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= {RESET_PC[31:2], 2'b00};
         addr_q  <= 32'h0;
         rd_q    <= 32'h0;
         npc_q   <= 32'h0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         npc_q   <= npc_d;
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   // Next-state logic: addr only moves on leaving IDLE, so it is stable while a
   // request is outstanding; redirects always invalidate the presented slot.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      npc_d   = npc_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               pc_d    = target;
               valid_d = 1'b0;
            end else if (slot_free) begin
               addr_d  = pc_q;
               valid_d = 1'b0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (redirect) begin
               pc_d    = target;
               valid_d = 1'b0;
               state_d = imem_ack ? S_IDLE : S_DISCARD;
            end else if (imem_ack) begin
               rd_d    = imem_rdata;
               npc_d   = addr_q + 32'd4;
               pc_d    = addr_q + 32'd4;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DISCARD: begin
            if (redirect) begin
               pc_d    = target;
               valid_d = 1'b0;
            end
            if (imem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      req_d = (state_d != S_IDLE);
   end

   // Outputs come straight from registers.
   always_comb begin
      imem_req  = req_q;
      imem_addr = addr_q;
      rd_out    = rd_q;
      newPC_out = npc_q;
      valid_out = valid_q;
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a stimulus driver with a memory responder and a
// program-order reference model feeds a scoreboard queue; an independent
// monitor pops and compares every newly presented instruction.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in, branch_taken, jump, imem_ack;
   logic [31:0] branch_target, jump_target, imem_rdata;
   logic        imem_req, valid_out;
   logic [31:0] imem_addr, rd_out, newPC_out;

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .rd_out(rd_out), .newPC_out(newPC_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rd;
      logic [31:0] npc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          deliveries = 0;
   bit          mon_en = 1'b0;

   // reference model state
   logic [31:0] model_pc;
   logic [31:0] req_addr_m;
   bit          live, prev_req;
   int          age, dly, cfg_dly;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h2002_0005;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // One clock: respond as memory, drive controls, advance the model, then edge.
   task automatic step(input bit st, input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt);
      bit          req, a, rd;
      logic [31:0] tgt;
      exp_t        e;
      req = imem_req;
      if (req && !prev_req) begin
         chk("req_addr", imem_addr, model_pc);
         req_addr_m = model_pc;
         live = 1'b1;
         age  = 0;
         dly  = (cfg_dly < 0) ? int'($urandom_range(0, 3)) : cfg_dly;
      end else if (req) begin
         chk("addr_stable", imem_addr, req_addr_m);
      end
      a = req && (age >= dly);
      imem_ack      = a;
      imem_rdata    = a ? mem(imem_addr) : $urandom;
      stall_in      = st;
      branch_taken  = b;
      branch_target = bt;
      jump          = j;
      jump_target   = jt;
      rd  = b | j;
      tgt = (b ? bt : jt) & ~32'h3;
      if (req && rd) live = 1'b0;
      if (a && live) begin
         e.rd  = mem(req_addr_m);
         e.npc = req_addr_m + 32'd4;
         q.push_back(e);
         model_pc = req_addr_m + 32'd4;
         live = 1'b0;
      end
      if (rd) model_pc = tgt;
      if (req) age++;
      prev_req = req;
      @(posedge clk); #1;
      imem_ack = 1'b0;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1;
      stall_in = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ack = 1'b0;
      @(posedge clk); #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_rd", rd_out, 0);
      chk("rst_npc", newPC_out, 0);
      chk("rst_valid", valid_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      model_pc = 32'h0000_0000;
      prev_req = 1'b0;
      live = 1'b0;
      mon_en = 1'b1;
   endtask

   // Monitor: scoreboard pops on each new presentation plus slot-protocol checks.
   bit          pv, ps, pr;
   logic [31:0] prd, pnpc;
   initial begin
      exp_t e;
      pv = 0; ps = 0; pr = 0; prd = 0; pnpc = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (valid_out && !pv) begin
               deliveries++;
               if (q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_valid: got valid_out=1 rd=%h, expected no instruction", rd_out);
               end else begin
                  e = q.pop_front();
                  chk("sb_rd", rd_out, e.rd);
                  chk("sb_npc", newPC_out, e.npc);
               end
            end
            if (pv && pr) chk("redir_clr", valid_out, 0);
            else if (pv && ps) begin
               chk("stall_valid", valid_out, 1);
               chk("stall_rd", rd_out, prd);
               chk("stall_npc", newPC_out, pnpc);
               chk("stall_noreq", imem_req, 0);
            end else if (pv) chk("consume", valid_out, 0);
         end
         pv = valid_out; prd = rd_out; pnpc = newPC_out;
         ps = stall_in;  pr = branch_taken | jump;
      end
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      bit found;
      logic [31:0] t;
      rst = 1'b1; stall_in = 0; branch_taken = 0; jump = 0; imem_ack = 0;
      branch_target = 0; jump_target = 0; imem_rdata = 0;
      cfg_dly = 1; age = 0; dly = 0; model_pc = 0; req_addr_m = 0; live = 0; prev_req = 0;
      do_reset();

      // back-to-back fetch from reset, ack one cycle after each request
      repeat (6) step(0, 0, 0, 0, 0);

      // hold a presented instruction under stall, then release
      repeat (10) step(1, 0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);

      // go to 8, branch to 0x40 while the request is outstanding, late ack
      cfg_dly = 4;
      step(0, 0, 0, 1, 32'h8);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (imem_req && !prev_req && imem_addr == 32'h8) found = 1;
         else step(0, 0, 0, 0, 0);
      end
      chk("busy_at_8", found, 1);
      step(0, 1, 32'h40, 0, 0);
      chk("discard_req", imem_req, 1);
      chk("discard_valid", valid_out, 0);
      repeat (8) step(0, 0, 0, 0, 0);

      // simultaneous branch and jump: branch wins, low bits cleared
      step(0, 1, 32'h103, 1, 32'h200);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (imem_req && !prev_req) found = 1;
         else step(0, 0, 0, 0, 0);
      end
      chk("prio_found", found, 1);
      chk("prio_addr", imem_addr, 32'h100);

      // wrap-around at the top of the address space, then reset mid-request
      cfg_dly = 0;
      step(0, 0, 0, 1, 32'hFFFF_FFFE);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         step(0, 0, 0, 0, 0);
         if (valid_out) found = 1;
      end
      chk("wrap_found", found, 1);
      chk("wrap_npc", newPC_out, 32'h0);
      chk("wrap_rd", rd_out, mem(32'hFFFF_FFFC));
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (imem_req && !prev_req) found = 1;
         else step(0, 0, 0, 0, 0);
      end
      chk("wrap_next_addr", imem_addr, 32'h0);
      chk("busy_before_rst", imem_req, 1);
      do_reset();

      // randomized traffic
      cfg_dly = -1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else begin
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
            step($urandom_range(0, 9) < 3,
                 $urandom_range(0, 15) == 0, t,
                 $urandom_range(0, 15) == 0, $urandom);
         end
      end

      // drain and confirm nothing expected is left undelivered
      repeat (20) step(0, 0, 0, 0, 0);
      @(negedge clk); #1;
      chk("drain_empty", q.size(), 0);
      chk("progress", deliveries >= 30, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
